act_requant: RTL

Post-array output stage for one column of the MAC array. Accepts signed `psum_bw` partial sums, accumulates them over a programmable number of passes into a `depth`-entry accumulator bank, then drains the bank as unsigned `abw`-bit activations for the next layer. Each psum passes through ReLU, arithmetic right-shift and saturation before it is written out. This is the inverse direction of the MAC: the MAC turns activations into psums, and this block turns psums back into activations.

---
 rtl/act_requant_pkg.sv | 15 +
 rtl/act_requant_if.sv | 25 ++
 rtl/act_requant_relu_sat.sv | 25 ++
 rtl/act_requant.sv | 124 ++++++++++++
 4 files changed

// File: rtl/act_requant_pkg.sv
// Shared widths and FSM encodings for the activation requantiser column stage.
package act_requant_pkg;

    localparam int PSUM_BW = 10;
    localparam int ABW     = 2;
    localparam int ACC_BW  = 16;
    localparam int DEPTH   = 16;
    localparam int NPASS_W = 4;
    localparam int SHIFT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/act_requant_if.sv
// Psum input stream and activation output stream of one requantiser column.
interface act_requant_if
    import act_requant_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int abw     = ABW
);
    logic                      in_valid;
    logic signed [psum_bw-1:0] in_psum;
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [abw-1:0]            out_act;
    logic                      out_last;

    modport slave (
        input  in_valid, in_psum, out_ready,
        output in_ready, out_valid, out_act, out_last
    );

    modport master (
        output in_valid, in_psum, out_ready,
        input  in_ready, out_valid, out_act, out_last
    );
endinterface

// File: rtl/act_requant_relu_sat.sv
// ReLU, floor right-shift and unsigned saturation of one accumulator value.
module relu_sat
    import act_requant_pkg::*;
#(
    parameter int acc_bw  = ACC_BW,
    parameter int abw     = ABW,
    parameter int shift_w = SHIFT_W
) (
    input  logic signed [acc_bw-1:0] value,
    input  logic [shift_w-1:0]       shift,
    output logic [abw-1:0]           act
);
    localparam logic [acc_bw-1:0] ACT_MAX = acc_bw'((1 << abw) - 1);

    logic [acc_bw-1:0] shifted;

    always_comb begin
        shifted = '0;
        act     = '0;
        if (!value[acc_bw-1]) begin
            shifted = $unsigned(value) >> shift;
            act     = (shifted > ACT_MAX) ? {abw{1'b1}} : shifted[abw-1:0];
        end
    end
endmodule

// File: rtl/act_requant.sv
// Accumulates psums over npass passes into a depth-entry bank, then drains it as activations.
//   state    | meaning
//   IDLE     | waiting for start
//   ACC      | accepting psums, idx walks the bank once per pass
//   DRAIN    | streaming requantised activations through the output register
module act_requant
    import act_requant_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int abw     = ABW,
    parameter int acc_bw  = ACC_BW,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NPASS_W-1:0] npass,
    input  logic [SHIFT_W-1:0] shift,
    act_requant_if.slave       bus,
    output logic               busy,
    output logic               done
);
    localparam int IDX_W = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(depth - 1);

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [NPASS_W-1:0]       pass;
    logic [NPASS_W-1:0]       npass_r;
    logic [SHIFT_W-1:0]       shift_r;
    logic signed [acc_bw-1:0] acc [depth];
    logic signed [acc_bw-1:0] psum_ext;
    logic signed [acc_bw-1:0] acc_sum;
    logic                     accept;
    logic                     pass_last;
    logic                     load_out;
    logic [abw-1:0]           act_next;
    logic                     out_valid_r;
    logic                     out_last_r;
    logic [abw-1:0]           out_act_r;

    assign bus.in_ready  = (state == ST_ACC);
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_act   = out_act_r;
    assign busy          = (state != ST_IDLE);

    assign accept    = bus.in_ready && bus.in_valid;
    assign psum_ext  = {{(acc_bw - psum_bw){bus.in_psum[psum_bw-1]}}, bus.in_psum};
    assign acc_sum   = (pass == '0) ? psum_ext : acc[idx] + psum_ext;
    assign pass_last = (pass == npass_r - 1'b1);
    // Refill the output register when it is empty or being consumed, but never past the last entry.
    assign load_out  = (state == ST_DRAIN) && (!out_valid_r || (bus.out_ready && !out_last_r));

    relu_sat #(
        .acc_bw  (acc_bw),
        .abw     (abw),
        .shift_w (SHIFT_W)
    ) u_relu_sat (
        .value (acc[idx]),
        .shift (shift_r),
        .act   (act_next)
    );

    // Bank has no reset: pass 0 always overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc[idx] <= acc_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pass        <= '0;
            npass_r     <= NPASS_W'(1);
            shift_r     <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_act_r   <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        npass_r <= (npass == '0) ? NPASS_W'(1) : npass;
                        shift_r <= shift;
                        idx     <= '0;
                        pass    <= '0;
                        state   <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            if (pass_last) begin
                                state <= ST_DRAIN;
                            end else begin
                                pass <= pass + 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_r && bus.out_ready && out_last_r) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (load_out) begin
                        out_act_r   <= act_next;
                        out_last_r  <= (idx == IDX_LAST);
                        out_valid_r <= 1'b1;
                        idx         <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
